tdm_demux_4: RTL and testbench
==============================

Name: tdm_demux_4

Overview:
- Receive-side counterpart of the 4:1 mux tree used as a time-division serializer.
- Takes one time-multiplexed data stream (slot order a, b, c, d) with a frame-start marker and routes each beat to one of four registered output lanes.
- Tracks slot position with a counter and sync state machine, flags framing errors and pulses on every complete frame.
- Sits directly after a serial/TDM link, feeding four parallel consumers.

Parameters:
- WIDTH, 1, data width of the stream and of each lane.
- REQUIRE_SYNC, 1, 1 = every frame must begin with frame_start; 0 = free-running after first sync.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- din  input  WIDTH  serial TDM data beat.
- din_valid  input  1  din carries a beat this cycle.
- frame_start  input  1  marks this beat as slot 0 (a); sampled only when din_valid=1.
- a  output  WIDTH  lane 0 register (slot 0).
- b  output  WIDTH  lane 1 register (slot 1).
- c  output  WIDTH  lane 2 register (slot 2).
- d  output  WIDTH  lane 3 register (slot 3).
- lane_stb  output  4  one-hot; bit k high for one cycle when lane k was just written.
- slot  output  2  slot index expected for the next beat.
- frame_done  output  1  one-cycle pulse: a..d all hold one complete, correctly ordered frame.
- sync_err  output  1  one-cycle pulse on a framing violation.

Behaviour:
- Reset, applied when rst=1 at a clk edge, overrides all inputs:
  - a, b, c, d = 0; lane_stb = 0; slot = 0; frame_done = 0; sync_err = 0; state = IDLE.
- A beat is a cycle with din_valid=1. Cycles with din_valid=0 change nothing except clearing lane_stb, frame_done and sync_err to 0.
- All outputs are registered, with 1-cycle latency. A beat at edge N makes its lane value, lane_stb, frame_done and sync_err visible after edge N.
- States:
  - IDLE: unsynchronised.
    - Beat with frame_start=1 -> a=din, lane_stb=0001, slot=1, go to RUN.
    - Beat with frame_start=0 -> discarded, no strobe, no error.
  - RUN, beat with frame_start=1:
    - slot==0 -> a=din, lane_stb=0001, slot=1.
    - slot!=0 -> sync_err=1 and the partial frame is abandoned (no frame_done). The beat still resyncs: a=din, lane_stb=0001, slot=1. Stays in RUN.
  - RUN, beat with frame_start=0 and slot in 1..3:
    - Write lane[slot]=din, lane_stb=one-hot(slot), slot increments.
    - At slot 3, slot wraps to 0 and frame_done=1 in the same cycle as the d update.
  - RUN, beat with frame_start=0 and slot==0:
    - REQUIRE_SYNC=1 -> sync_err=1, beat discarded, go to IDLE, slot stays 0.
    - REQUIRE_SYNC=0 -> treated as slot 0: a=din, lane_stb=0001, slot=1.
- Lanes hold their values until rewritten. A resync leaves stale b..d in place. Consumers qualify reads with frame_done or lane_stb.
- frame_done is asserted only if slots 0..3 were written in order without an intervening sync_err or IDLE entry.
- Back-to-back beats every cycle are supported, with no bubbles required. Consecutive frames may abut: the slot-3 beat is followed next cycle by the frame_start beat.
- Reset mid-frame discards the partial frame, and the next frame requires frame_start.

Decomposition:
- Shared package tdm_pkg:
  - slot constants SLOT_A=2'd0, SLOT_B=2'd1, SLOT_C=2'd2, SLOT_D=2'd3.
  - state encoding IDLE/RUN.
  - shared by the transmit-side TDM serializer.
- Sub-module tdm_slot_ctr:
  - 2-bit counter with synchronous clear, load-to-1 on sync, increment-with-wrap on beat, and a wrap flag.
  - Top level holds the FSM, lane registers and strobes.

Test Plan:
- Reset, then beats {fs=1,din=1},{0,0},{0,1},{0,1} on consecutive cycles, WIDTH=1 -> after 4th edge a=1, b=0, c=1, d=1; frame_done pulses once; lane_stb sequence 0001,0010,0100,1000.
- IDLE, three beats with fs=0 -> a..d stay 0, lane_stb=0, sync_err=0, slot=0; a following fs=1 beat -> a updated, slot=1.
- RUN at slot=2, then a beat with fs=1, din=1 -> sync_err=1 for one cycle, a=1, slot=1, no frame_done; the next 3 beats complete the frame -> frame_done=1.
- REQUIRE_SYNC=1: after a complete frame, a beat with fs=0 -> sync_err=1, state IDLE, a unchanged; REQUIRE_SYNC=0: same stimulus -> a=din, lane_stb=0001.
- Two abutting frames, 8 consecutive beats with din_valid gaps of 0 and 2 cycles inserted mid-frame -> frame_done exactly twice, aligned with the d writes; gap cycles show lane_stb=0.
- rst=1 asserted at slot=2 mid-frame -> all outputs 0 next cycle; subsequent fs=0 beats ignored until fs=1.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared TDM definitions: slot indices, sync state encoding and a slot decode helper.
// The transmit-side serializer uses the same package.
package tdm_pkg;

  localparam logic [1:0] SLOT_A = 2'd0;
  localparam logic [1:0] SLOT_B = 2'd1;
  localparam logic [1:0] SLOT_C = 2'd2;
  localparam logic [1:0] SLOT_D = 2'd3;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } tdm_state_e;

  function automatic logic [3:0] slot_onehot(input logic [1:0] s);
    return 4'b0001 << s;
  endfunction

endpackage

// File: rtl/tdm_slot_ctr.sv
// 2-bit TDM slot position counter: clear, load-to-1 on sync, wrapping increment on beat.
// wrap_o flags the increment out of the last slot in the same cycle.
module tdm_slot_ctr
  import tdm_pkg::*;
(
  input  logic       clk,
  input  logic       clr_i,
  input  logic       sync_i,
  input  logic       inc_i,
  output logic [1:0] slot_o,
  output logic       wrap_o
);

  logic [1:0] slot_q, slot_d;

  always_comb begin
    slot_d = slot_q;
    if (clr_i) begin
      slot_d = SLOT_A;
    end else if (sync_i) begin
      slot_d = SLOT_B;
    end else if (inc_i) begin
      slot_d = slot_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    slot_q <= slot_d;
  end

  assign slot_o = slot_q;
  assign wrap_o = inc_i && !clr_i && !sync_i && (slot_q == SLOT_D);

endmodule

// File: rtl/tdm_demux_4.sv
// 1:4 TDM demultiplexer: routes slot-ordered beats into four registered lanes,
// tracks frame sync, pulses frame_done on complete frames and sync_err on violations.
module tdm_demux_4
  import tdm_pkg::*;
#(
  parameter int WIDTH        = 1,
  parameter bit REQUIRE_SYNC = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             frame_start,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic [3:0]       lane_stb,
  output logic [1:0]       slot,
  output logic             frame_done,
  output logic             sync_err
);

  tdm_state_e state_q, state_d;

  logic [WIDTH-1:0] lane_q [4];
  logic [3:0]       lane_stb_q;
  logic             frame_done_q;
  logic             sync_err_q;

  logic [3:0] wr_en;
  logic       ctr_sync, ctr_inc, ctr_clr, err_d;
  logic [1:0] slot_cur;
  logic       slot_wrap;

  tdm_slot_ctr u_slot_ctr (
    .clk    (clk),
    .clr_i  (rst || ctr_clr),
    .sync_i (ctr_sync),
    .inc_i  (ctr_inc),
    .slot_o (slot_cur),
    .wrap_o (slot_wrap)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (din_valid && frame_start) state_d = RUN;
      RUN: begin
        if (din_valid && !frame_start && slot_cur == SLOT_A && REQUIRE_SYNC)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_en    = 4'b0000;
    ctr_sync = 1'b0;
    ctr_inc  = 1'b0;
    ctr_clr  = 1'b0;
    err_d    = 1'b0;
    if (din_valid) begin
      unique case (state_q)
        IDLE: begin
          if (frame_start) begin
            wr_en    = slot_onehot(SLOT_A);
            ctr_sync = 1'b1;
          end
        end
        RUN: begin
          if (frame_start) begin
            // A misplaced frame_start abandons the partial frame but still resyncs
            wr_en    = slot_onehot(SLOT_A);
            ctr_sync = 1'b1;
            err_d    = (slot_cur != SLOT_A);
          end else if (slot_cur != SLOT_A) begin
            wr_en   = slot_onehot(slot_cur);
            ctr_inc = 1'b1;
          end else if (REQUIRE_SYNC) begin
            err_d   = 1'b1;
            ctr_clr = 1'b1;
          end else begin
            wr_en    = slot_onehot(SLOT_A);
            ctr_sync = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) lane_q[k] <= '0;
      lane_stb_q   <= 4'b0000;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (wr_en[k]) lane_q[k] <= din;
      end
      lane_stb_q   <= wr_en;
      frame_done_q <= slot_wrap;
      sync_err_q   <= err_d;
    end
  end

  assign a          = lane_q[0];
  assign b          = lane_q[1];
  assign c          = lane_q[2];
  assign d          = lane_q[3];
  assign lane_stb   = lane_stb_q;
  assign slot       = slot_cur;
  assign frame_done = frame_done_q;
  assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_tdm_demux_4.sv
// Directed bench for tdm_demux_4; two instances differ only in REQUIRE_SYNC.
module tb_tdm_demux_4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [0:0] din = '0;
  logic       din_valid = 1'b0;
  logic       frame_start = 1'b0;

  logic [0:0] a1, b1, c1, d1, a0, b0, c0, d0;
  logic [3:0] stb1, stb0;
  logic [1:0] slot1, slot0;
  logic       done1, done0, err1, err0;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt;

  always #5 clk = ~clk;

  tdm_demux_4 #(.WIDTH(1), .REQUIRE_SYNC(1'b1)) u_rs1 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .frame_start(frame_start),
    .a(a1), .b(b1), .c(c1), .d(d1), .lane_stb(stb1), .slot(slot1),
    .frame_done(done1), .sync_err(err1)
  );

  tdm_demux_4 #(.WIDTH(1), .REQUIRE_SYNC(1'b0)) u_rs0 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .frame_start(frame_start),
    .a(a0), .b(b0), .c(c0), .d(d0), .lane_stb(stb0), .slot(slot0),
    .frame_done(done0), .sync_err(err0)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, then sample 1 time unit after the rising edge
  task automatic step(input logic r, input logic v, input logic fs, input logic dv);
    @(negedge clk);
    rst = r; din_valid = v; frame_start = fs; din = dv;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_lanes(input string tag, input int ea, input int eb, input int ec, input int ed);
    chk({tag, ".a"}, int'(a1), ea);
    chk({tag, ".b"}, int'(b1), eb);
    chk({tag, ".c"}, int'(c1), ec);
    chk({tag, ".d"}, int'(d1), ed);
  endtask

  initial begin
    // Reset
    step(1, 1, 1, 1);
    step(1, 0, 0, 0);
    chk_lanes("rst", 0, 0, 0, 0);
    chk("rst.stb", stb1, 0);
    chk("rst.slot", slot1, 0);
    chk("rst.done", done1, 0);
    chk("rst.err", err1, 0);

    // Basic frame a=1,b=0,c=1,d=1
    step(0, 1, 1, 1);
    chk("f1.stb0", stb1, 4'b0001); chk("f1.slot0", slot1, 1); chk("f1.done0", done1, 0);
    step(0, 1, 0, 0);
    chk("f1.stb1", stb1, 4'b0010); chk("f1.slot1", slot1, 2); chk("f1.done1", done1, 0);
    step(0, 1, 0, 1);
    chk("f1.stb2", stb1, 4'b0100); chk("f1.slot2", slot1, 3); chk("f1.done2", done1, 0);
    step(0, 1, 0, 1);
    chk("f1.stb3", stb1, 4'b1000); chk("f1.slot3", slot1, 0); chk("f1.done3", done1, 1);
    chk_lanes("f1", 1, 0, 1, 1);
    step(0, 0, 0, 0);
    chk("f1.idle_stb", stb1, 0); chk("f1.idle_done", done1, 0);

    // fs=0 beat at slot 0: REQUIRE_SYNC decides
    step(0, 1, 0, 0);
    chk("rs1.err", err1, 1); chk("rs1.a", a1, 1); chk("rs1.stb", stb1, 0); chk("rs1.slot", slot1, 0);
    chk("rs0.err", err0, 0); chk("rs0.a", a0, 0); chk("rs0.stb", stb0, 4'b0001); chk("rs0.slot", slot0, 1);
    step(0, 1, 0, 1);
    chk("rs1.idle_ign_err", err1, 0); chk("rs1.idle_ign_stb", stb1, 0); chk("rs1.idle_ign_d", d1, 1);

    // Reset, then IDLE discards fs=0 beats
    step(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 1);
      chk_lanes("idle", 0, 0, 0, 0);
      chk("idle.stb", stb1, 0); chk("idle.err", err1, 0); chk("idle.slot", slot1, 0);
    end
    step(0, 1, 1, 1);
    chk("idle.sync_a", a1, 1); chk("idle.sync_slot", slot1, 1); chk("idle.sync_stb", stb1, 4'b0001);

    // Misplaced frame_start at slot 2
    step(0, 1, 0, 1);
    chk("mis.slot", slot1, 2); chk("mis.b", b1, 1);
    step(0, 1, 1, 1);
    chk("mis.err", err1, 1); chk("mis.a", a1, 1); chk("mis.slot_rs", slot1, 1);
    chk("mis.done", done1, 0); chk("mis.stb", stb1, 4'b0001);
    step(0, 1, 0, 0);
    chk("mis.err_clr", err1, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    chk("mis.done_end", done1, 1); chk_lanes("mis", 1, 0, 0, 0);

    // Abutting frames with mid-frame gaps of 2 and 0 cycles
    done_cnt = 0;
    begin
      logic [3:0] vec [12];  // {valid, fs, din, pad}
      vec = '{4'b1100, 4'b1010, 4'b0000, 4'b0000, 4'b1000, 4'b1010,
              4'b1110, 4'b1000, 4'b1010, 4'b1000, 4'b0000, 4'b0000};
      for (int i = 0; i < 12; i++) begin
        logic [3:0] v;
        v = vec[i];
        step(0, v[3], v[2], v[1]);
        if (done1) done_cnt++;
        chk($sformatf("abut.align%0d", i), int'(done1), int'(stb1 == 4'b1000));
        if (!v[3]) chk($sformatf("abut.gap_stb%0d", i), stb1, 0);
      end
    end
    chk("abut.done_cnt", done_cnt, 2);
    chk_lanes("abut", 1, 0, 1, 0);

    // Reset mid-frame at slot 2
    step(0, 1, 1, 1);
    step(0, 1, 0, 1);
    chk("mrst.slot_pre", slot1, 2);
    step(1, 1, 0, 1);
    chk_lanes("mrst", 0, 0, 0, 0);
    chk("mrst.stb", stb1, 0); chk("mrst.slot", slot1, 0);
    chk("mrst.done", done1, 0); chk("mrst.err", err1, 0);
    step(0, 1, 0, 1);
    step(0, 1, 0, 1);
    chk("mrst.ign_a", a1, 0); chk("mrst.ign_slot", slot1, 0); chk("mrst.ign_stb", stb1, 0);
    chk("mrst.ign_slot_rs0", slot0, 0);
    step(0, 1, 1, 1);
    chk("mrst.sync_a", a1, 1); chk("mrst.sync_slot", slot1, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
